// File: rtl/ps2_mouse_init_ctrl_if.sv
// ps2_mouse_init_ctrl_if: byte-level handshake between the mouse init
// controller and the shared ps2_rxtx transceiver.
//
// Signals:
//   rx_data       8  received byte (transceiver -> controller)
//   rx_done_tick  1  one-cycle strobe, rx_data valid
//   tx_done_tick  1  one-cycle strobe, byte transmitted
//   wr_ps2        1  one-cycle transmit request (controller -> transceiver)
//   tx_data       8  byte to transmit
//
// Modports: master = init controller, slave = transceiver side.
interface ps2_mouse_init_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       tx_done_tick;
  logic       wr_ps2;
  logic [7:0] tx_data;

  modport master (
    input  rx_data,
    input  rx_done_tick,
    input  tx_done_tick,
    output wr_ps2,
    output tx_data
  );

  modport slave (
    output rx_data,
    output rx_done_tick,
    output tx_done_tick,
    input  wr_ps2,
    input  tx_data
  );
endinterface

// File: rtl/ps2_mouse_init_ctrl.sv
// ps2_mouse_init_ctrl: PS/2 mouse bring-up sequencer.
//
// Sends reset (0xFF), sample rate (0xF3 + SAMPLE_RATE), resolution
// (0xE8 + RESOLUTION) and enable streaming (0xF4) through ps2_rxtx, checks
// every ACK / BAT / ID reply and restarts the whole sequence on failure up
// to MAX_RETRY times before parking in an error state.
//
// Optional build macro PS2_INIT_INTELLIMOUSE_EN: inserts the IntelliMouse
// magic rate sequence (200/100/80) plus a get-ID (0xF2) before 0xF4 and
// reports a wheel mouse (ID 0x03) on wheel_present.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   ps2            master side of ps2_mouse_init_ctrl_if (rx/tx handshake)
//   start          pulse, (re)start from idle, done or error
//   busy           sequence in progress
//   init_done      mouse streaming enabled
//   init_err       retries exhausted
//   err_code       last failure: 1 tx timeout, 2 ack timeout, 3 BAT,
//                  4 bad ID, 5 NAK / unexpected byte
//   wheel_present  mouse reported ID 0x03
module ps2_mouse_init_ctrl #(
  parameter logic [7:0]  SAMPLE_RATE = 8'd100,
  parameter logic [7:0]  RESOLUTION  = 8'h02,
  parameter int unsigned ACK_TIMEOUT = 1_000_000,
  parameter int unsigned BAT_TIMEOUT = 25_000_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  ps2_mouse_init_ctrl_if.master ps2,
  input  logic                  start,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [2:0]            err_code,
  output logic                  wheel_present
);

  typedef enum logic [3:0] {
    StIdle, StSend, StWaitTx, StWaitAck, StWaitBat, StWaitId, StNext, StDone, StError
  } state_e;

  localparam int unsigned MaxTimeout = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
  localparam int unsigned TimerW     = (MaxTimeout < 2) ? 1 : $clog2(MaxTimeout + 1);
  localparam int unsigned RetryW     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TimerW-1:0] AckLoad = TimerW'(ACK_TIMEOUT);
  localparam logic [TimerW-1:0] BatLoad = TimerW'(BAT_TIMEOUT);

  localparam logic [7:0] AckByte    = 8'hFA;
  localparam logic [7:0] ResendByte = 8'hFE;
  localparam logic [7:0] BatByte    = 8'hAA;

`ifdef PS2_INIT_INTELLIMOUSE_EN
  localparam logic [3:0] LastStep = 4'd12;
  localparam logic [3:0] IdStep   = 4'd11;
`else
  localparam logic [3:0] LastStep = 4'd5;
`endif

  function automatic logic [7:0] step_byte(input logic [3:0] s);
    logic [7:0] b;
`ifdef PS2_INIT_INTELLIMOUSE_EN
    case (s)
      4'd0:                b = 8'hFF;
      4'd1, 4'd5, 4'd7, 4'd9: b = 8'hF3;
      4'd2:                b = SAMPLE_RATE;
      4'd3:                b = 8'hE8;
      4'd4:                b = RESOLUTION;
      4'd6:                b = 8'hC8;
      4'd8:                b = 8'h64;
      4'd10:               b = 8'h50;
      4'd11:               b = 8'hF2;
      default:             b = 8'hF4;
    endcase
`else
    case (s)
      4'd0:    b = 8'hFF;
      4'd1:    b = 8'hF3;
      4'd2:    b = SAMPLE_RATE;
      4'd3:    b = 8'hE8;
      4'd4:    b = RESOLUTION;
      default: b = 8'hF4;
    endcase
`endif
    return b;
  endfunction

  state_e              state_q;
  logic [3:0]          step_q;
  logic [RetryW-1:0]   retry_q;
  logic [1:0]          resend_q;
  logic [TimerW-1:0]   timer_q;
  logic                auto_q;

  logic                id_step;
  logic                launch;
  logic                fail;
  logic [2:0]          fail_code;
  logic                timer_zero;

`ifdef PS2_INIT_INTELLIMOUSE_EN
  assign id_step = (step_q == IdStep);
`else
  assign id_step = 1'b0;
`endif

  assign timer_zero = (timer_q == '0);
  assign launch = (state_q == StIdle || state_q == StDone || state_q == StError) &&
                  (start || (state_q == StIdle && auto_q));

  // Failure detection; a received byte always takes priority over expiry.
  always_comb begin
    fail      = 1'b0;
    fail_code = 3'd0;
    unique case (state_q)
      StWaitTx: begin
        if (!ps2.tx_done_tick && timer_zero) begin
          fail      = 1'b1;
          fail_code = 3'd1;
        end
      end
      StWaitAck: begin
        if (ps2.rx_done_tick) begin
          if (ps2.rx_data != AckByte &&
              (ps2.rx_data != ResendByte || resend_q == 2'd3)) begin
            fail      = 1'b1;
            fail_code = 3'd5;
          end
        end else if (timer_zero) begin
          fail      = 1'b1;
          fail_code = 3'd2;
        end
      end
      StWaitBat: begin
        if ((ps2.rx_done_tick && ps2.rx_data != BatByte) ||
            (!ps2.rx_done_tick && timer_zero)) begin
          fail      = 1'b1;
          fail_code = 3'd3;
        end
      end
      StWaitId: begin
        if (ps2.rx_done_tick) begin
          if (ps2.rx_data != 8'h00 && !(id_step && ps2.rx_data == 8'h03)) begin
            fail      = 1'b1;
            fail_code = 3'd4;
          end
        end else if (timer_zero) begin
          fail      = 1'b1;
          fail_code = id_step ? 3'd4 : 3'd2;
        end
      end
      default: begin
        fail      = 1'b0;
        fail_code = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      step_q        <= '0;
      retry_q       <= '0;
      resend_q      <= '0;
      timer_q       <= '0;
      auto_q        <= AUTO_START;
      ps2.wr_ps2    <= 1'b0;
      ps2.tx_data   <= 8'h00;
      busy          <= 1'b0;
      init_done     <= 1'b0;
      init_err      <= 1'b0;
      err_code      <= 3'd0;
      wheel_present <= 1'b0;
    end else begin
      ps2.wr_ps2 <= 1'b0;
      if (launch) begin
        state_q       <= StSend;
        step_q        <= '0;
        retry_q       <= '0;
        resend_q      <= '0;
        timer_q       <= '0;
        auto_q        <= 1'b0;
        ps2.wr_ps2    <= 1'b1;
        ps2.tx_data   <= step_byte(4'd0);
        busy          <= 1'b1;
        init_done     <= 1'b0;
        init_err      <= 1'b0;
        err_code      <= 3'd0;
        wheel_present <= 1'b0;
      end else if (fail) begin
        err_code <= fail_code;
        resend_q <= '0;
        timer_q  <= '0;
        if (32'(retry_q) < MAX_RETRY) begin
          retry_q     <= retry_q + 1'b1;
          step_q      <= '0;
          state_q     <= StSend;
          ps2.wr_ps2  <= 1'b1;
          ps2.tx_data <= step_byte(4'd0);
        end else begin
          state_q  <= StError;
          init_err <= 1'b1;
          busy     <= 1'b0;
        end
      end else begin
        unique case (state_q)
          StSend: begin
            state_q <= StWaitTx;
            timer_q <= AckLoad;
          end
          StWaitTx: begin
            if (ps2.tx_done_tick) begin
              state_q <= StWaitAck;
              timer_q <= AckLoad;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
          StWaitAck: begin
            if (ps2.rx_done_tick) begin
              if (ps2.rx_data == AckByte) begin
                if (step_q == 4'd0) begin
                  state_q <= StWaitBat;
                  timer_q <= BatLoad;
                end else if (id_step) begin
                  state_q <= StWaitId;
                  timer_q <= AckLoad;
                end else begin
                  state_q <= StNext;
                  timer_q <= '0;
                end
              end else begin
                // Resend request: same byte again, tx_data already holds it.
                resend_q   <= resend_q + 1'b1;
                state_q    <= StSend;
                ps2.wr_ps2 <= 1'b1;
                timer_q    <= '0;
              end
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
          StWaitBat: begin
            if (ps2.rx_done_tick) begin
              state_q <= StWaitId;
              timer_q <= AckLoad;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
          StWaitId: begin
            if (ps2.rx_done_tick) begin
              state_q <= StNext;
              timer_q <= '0;
              if (id_step) begin
                wheel_present <= (ps2.rx_data == 8'h03);
              end
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
          StNext: begin
            if (step_q == LastStep) begin
              state_q   <= StDone;
              init_done <= 1'b1;
              busy      <= 1'b0;
            end else begin
              step_q      <= step_q + 1'b1;
              resend_q    <= '0;
              state_q     <= StSend;
              ps2.wr_ps2  <= 1'b1;
              ps2.tx_data <= step_byte(step_q + 1'b1);
            end
          end
          default: begin
            timer_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_mouse_init_ctrl.md
Name: ps2_mouse_init_ctrl

Overview:
- Sequences PS/2 mouse bring-up over the shared ps2_rxtx transceiver. Sends reset, sample-rate, resolution and enable-streaming commands, checks each ACK/BAT/ID reply, and retries on failure.
- Sits between ps2_rxtx and the packet decoder.
- On success it asserts init_done. The decoder then owns rx_data; this block stops driving wr_ps2.

Parameters:
- SAMPLE_RATE, 8'd100: argument byte sent after 0xF3.
- RESOLUTION, 8'h02: argument byte sent after 0xE8.
- ACK_TIMEOUT, 1_000_000: clk cycles allowed for tx_done_tick or for an ACK (20 ms at 50 MHz).
- BAT_TIMEOUT, 25_000_000: clk cycles allowed for the BAT byte 0xAA after reset ACK.
- MAX_RETRY, 3: full-sequence restarts before entering ERROR.
- AUTO_START, 1: 1 = begin sequence automatically on the first cycle after reset deasserts.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  pulse: (re)start the sequence from IDLE, DONE or ERROR.
- rx_data  in  8  received byte from ps2_rxtx.
- rx_done_tick  in  1  one-cycle strobe: rx_data valid.
- tx_done_tick  in  1  one-cycle strobe: byte transmitted.
- wr_ps2  out  1  one-cycle transmit request to ps2_rxtx.
- tx_data  out  8  byte to transmit; stable from SEND until the step ends.
- busy  out  1  sequence in progress.
- init_done  out  1  level: mouse streaming enabled.
- init_err  out  1  level: retries exhausted.
- err_code  out  3  1=tx timeout, 2=ack timeout, 3=BAT timeout/bad BAT, 4=bad ID, 5=NAK 0xFC/unexpected byte.
- wheel_present  out  1  mouse reported ID 0x03.

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, retry count=0, timer=0, step=0.
- Reset values: wr_ps2=0, tx_data=0x00, busy=0, init_done=0, init_err=0, err_code=0, wheel_present=0.
- Reset mid-sequence aborts immediately; no partial wr_ps2 pulse is produced.
- States: IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID, NEXT, DONE, ERROR.
- Step table (byte : replies expected after 0xFA ACK):
  - 0: 0xFF : then 0xAA, then 0x00.
  - 1: 0xF3.
  - 2: SAMPLE_RATE.
  - 3: 0xE8.
  - 4: RESOLUTION.
  - 5: 0xF4.
- IDLE → SEND on start, or on the first post-reset cycle if AUTO_START=1. Clears retry count, step, init_done and init_err.
- SEND:
  - wr_ps2=1 for exactly one cycle; tx_data=table[step] on that same cycle.
  - Next state is WAIT_TX; timer loads ACK_TIMEOUT.
- WAIT_TX:
  - tx_done_tick → WAIT_ACK, timer reloads ACK_TIMEOUT.
  - rx_done_tick here is ignored.
  - Timer reaching 0 → retry (err_code 1).
- WAIT_ACK:
  - rx 0xFA → WAIT_BAT if step 0 (timer loads BAT_TIMEOUT), else NEXT.
  - rx 0xFE (resend) → SEND with the same byte. Does not consume a retry, but the resend itself is bounded to 3 per step; the 4th 0xFE → retry (code 5).
  - rx any other byte → retry (code 5).
  - Timeout → retry (code 2).
- WAIT_BAT:
  - rx 0xAA → WAIT_ID, timer loads ACK_TIMEOUT.
  - rx other byte or timeout → retry (code 3).
- WAIT_ID: rx 0x00 → NEXT; other byte → retry (code 4); timeout → retry (code 2).
- NEXT: step+1 → SEND; after step 5 → DONE.
- DONE: init_done=1, busy=0. start → SEND sequence again.
- Retry:
  - If retry count < MAX_RETRY: increment it, step=0, → SEND.
  - Otherwise → ERROR: init_err=1, err_code holds the last cause, busy=0.
  - ERROR exits only on start or reset.
- busy=1 in every state except IDLE, DONE, ERROR. start while busy is ignored.
- Simultaneous rx_done_tick and timer expiry in the same cycle: the received byte wins.
- Timer is a down-counter sized by clog2 of the larger timeout; it holds at 0 outside wait states.
- Latency: start at cycle n → wr_ps2 high at cycle n+1.

Optional Feature:
- Macro: PS2_INIT_INTELLIMOUSE_EN.
- When defined, six steps are inserted after step 4 (RESOLUTION): 0xF3,0xC8, 0xF3,0x64, 0xF3,0x50 (each ACKed). Then 0xF2 (get ID): after 0xFA, the next rx byte is the ID.
  - ID 0x03 → wheel_present=1.
  - ID 0x00 → wheel_present=0.
  - Any other ID, or a timeout on the ID byte → retry (code 4).
- Step 5 (0xF4) follows last.
- When undefined: original 6-step sequence; wheel_present tied 0.

Test Plan:
- Ideal mouse:
  - Stimulus: AUTO_START=1; model ACKs everything and returns 0xAA, 0x00 after the 0xFF ACK.
  - Response: bytes FF,F3,64,E8,02,F4 sent in order, one wr_ps2 pulse each; init_done=1; busy=0; err_code=0.
- Resend: model answers the first 0xF3 with 0xFE → 0xF3 retransmitted once; sequence completes; retry count unchanged.
- BAT timeout:
  - Stimulus: BAT_TIMEOUT=50, MAX_RETRY=1; model never sends 0xAA.
  - Response: 0xFF sent twice; then init_err=1, err_code=3, busy=0.
- Race and ignored input:
  - rx_done_tick carrying 0xFA on the exact cycle the ACK timer expires → accepted as ACK.
  - start pulsed while busy → no restart.
- Reset mid-sequence: reset low during WAIT_ACK of step 3 → all outputs at reset values next cycle. With AUTO_START=1, a fresh sequence starts from 0xFF after release.
- With PS2_INIT_INTELLIMOUSE_EN: model returns ID 0x03 after 0xF2 → F3 C8 F3 64 F3 50 F2 observed before F4; wheel_present=1; init_done=1.
